// File: rtl/otter_bp_pkg.sv
// Shared types and helpers for the OTTER branch predictor: counter operations,
// counter constants and BTB index/tag extraction.
package otter_bp_pkg;

    // Operation applied to the direction counter of the addressed entry.
    typedef enum logic [2:0] {
        CNT_HOLD,
        CNT_INC,
        CNT_DEC,
        CNT_SET_MAX,
        CNT_SET_INIT
    } cnt_op_e;

    // Value given to a freshly allocated entry: weakly taken.
    function automatic int cnt_init(input int cnt_w);
        return 1 << (cnt_w - 1);
    endfunction

    // Reset value: weakly not-taken.
    function automatic int cnt_rst(input int cnt_w);
        return (1 << (cnt_w - 1)) - 1;
    endfunction

    // Saturation ceiling.
    function automatic int cnt_max(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

    // BTB index: word-aligned PC bits just above the byte offset.
    function automatic logic [31:0] bp_idx(input logic [31:0] pc, input int idx_w);
        return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    // BTB tag: every PC bit above the index.
    function automatic logic [31:0] bp_tag(input logic [31:0] pc, input int idx_w);
        return pc >> (idx_w + 2);
    endfunction

endpackage

// File: rtl/otter_sat_counter.sv
// Next-value logic for a saturating direction counter; applied to the one
// entry addressed by the instruction resolving in EX.
module otter_sat_counter
    import otter_bp_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic [CNT_W-1:0] cnt_i,
    input  cnt_op_e          op_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX_V  = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] CNT_INIT_V = CNT_W'(cnt_init(CNT_W));

    // Saturating increment/decrement, clamped at 0 and at the ceiling.
    always_comb begin
        // NOTE: cnt_o is assigned on every path (default first), so no latch is inferred.
        cnt_o = cnt_i;
        case (op_i)
            CNT_INC:      cnt_o = (cnt_i == CNT_MAX_V) ? cnt_i : cnt_i + CNT_W'(1);
            CNT_DEC:      cnt_o = (cnt_i == '0) ? cnt_i : cnt_i - CNT_W'(1);
            CNT_SET_MAX:  cnt_o = CNT_MAX_V;
            CNT_SET_INIT: cnt_o = CNT_INIT_V;
            default:      cnt_o = cnt_i;
        endcase
    end

endmodule

// File: rtl/otter_branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters. Predicts the
// next fetch PC in IF, trains from resolved control flow in EX, and flags
// mispredicts with the corrected PC. Also keeps control/mispredict statistics.
module otter_branch_predictor
    import otter_bp_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int CNT_W   = 2,
    parameter int STAT_W  = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              IF_VALID,
    input  logic [31:0]       IF_PC,
    output logic              PRED_TAKEN,
    output logic [31:0]       PRED_TARGET,
    input  logic              EX_VALID,
    input  logic [31:0]       EX_PC,
    input  logic              EX_IS_BRANCH,
    input  logic              EX_IS_JUMP,
    input  logic              EX_TAKEN,
    input  logic [31:0]       EX_TARGET,
    input  logic              EX_PRED_TAKEN,
    input  logic [31:0]       EX_PRED_TARGET,
    input  logic              INVALIDATE,
    output logic              EX_MISPREDICT,
    output logic [31:0]       EX_REDIRECT_PC,
    output logic [STAT_W-1:0] STAT_CTRL,
    output logic [STAT_W-1:0] STAT_MISS
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 32 - IDX_W - 2;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        logic             jump;
        logic [CNT_W-1:0] cnt;
    } bp_entry_t;

    localparam bp_entry_t ENTRY_RST = '{
        valid:  1'b0,
        tag:    '0,
        target: '0,
        jump:   1'b0,
        cnt:    CNT_W'(cnt_rst(CNT_W))
    };

    bp_entry_t         entry_q [ENTRIES];
    bp_entry_t         entry_d [ENTRIES];
    logic [STAT_W-1:0] stat_ctrl_q, stat_ctrl_d;
    logic [STAT_W-1:0] stat_miss_q, stat_miss_d;

    logic [IDX_W-1:0]  if_idx, ex_idx;
    logic [TAG_W-1:0]  if_tag, ex_tag;
    bp_entry_t         if_entry, ex_entry;
    logic              if_hit, ex_hit, ex_ctrl;
    cnt_op_e           cnt_op;
    logic [CNT_W-1:0]  cnt_nxt;

    assign if_idx   = IDX_W'(bp_idx(IF_PC, IDX_W));
    assign if_tag   = TAG_W'(bp_tag(IF_PC, IDX_W));
    assign ex_idx   = IDX_W'(bp_idx(EX_PC, IDX_W));
    assign ex_tag   = TAG_W'(bp_tag(EX_PC, IDX_W));
    assign if_entry = entry_q[if_idx];
    assign ex_entry = entry_q[ex_idx];
    assign if_hit   = if_entry.valid && (if_entry.tag == if_tag);
    assign ex_hit   = ex_entry.valid && (ex_entry.tag == ex_tag);
    assign ex_ctrl  = EX_IS_BRANCH || EX_IS_JUMP;

    // Same-cycle prediction from pre-update BTB state.
    always_comb begin
        PRED_TAKEN  = IF_VALID && if_hit && (if_entry.jump || if_entry.cnt[CNT_W-1]);
        PRED_TARGET = PRED_TAKEN ? if_entry.target : IF_PC + 32'd4;
    end

    // Resolve: compare the piped prediction with the real outcome.
    always_comb begin
        EX_MISPREDICT = EX_VALID && (
            (ex_ctrl && (EX_PRED_TAKEN != EX_TAKEN)) ||
            (ex_ctrl && EX_TAKEN && (EX_PRED_TARGET != EX_TARGET)) ||
            (!ex_ctrl && EX_PRED_TAKEN));
        EX_REDIRECT_PC = (ex_ctrl && EX_TAKEN) ? EX_TARGET : EX_PC + 32'd4;
    end

    // Choose the counter update for the entry addressed by EX.
    always_comb begin
        cnt_op = CNT_HOLD;
        if (ex_ctrl) begin
            if (EX_IS_JUMP)    cnt_op = CNT_SET_MAX;
            else if (!ex_hit)  cnt_op = CNT_SET_INIT;
            else if (EX_TAKEN) cnt_op = CNT_INC;
            else               cnt_op = CNT_DEC;
        end
    end

    otter_sat_counter #(.CNT_W(CNT_W)) u_sat_counter (
        .cnt_i (ex_entry.cnt),
        .op_i  (cnt_op),
        .cnt_o (cnt_nxt)
    );

    // Next BTB contents: train, alias kill, then invalidate overrides everything.
    always_comb begin
        // NOTE: blocking assignments here build combinational next-state; only the always_ff uses <=.
        entry_d = entry_q;
        if (EX_VALID && ex_ctrl) begin
            if (ex_hit) begin
                entry_d[ex_idx].cnt  = cnt_nxt;
                entry_d[ex_idx].jump = EX_IS_JUMP;
                if (EX_TAKEN) entry_d[ex_idx].target = EX_TARGET;
            end else if (EX_TAKEN) begin
                entry_d[ex_idx] = '{valid: 1'b1, tag: ex_tag, target: EX_TARGET,
                                    jump: EX_IS_JUMP, cnt: cnt_nxt};
            end
        end else if (EX_VALID && EX_PRED_TAKEN && ex_hit) begin
            entry_d[ex_idx].valid = 1'b0;
        end
        if (INVALIDATE) begin
            for (int i = 0; i < ENTRIES; i++) entry_d[i].valid = 1'b0;
        end
    end

    // Statistics counters wrap naturally at 2^STAT_W.
    always_comb begin
        stat_ctrl_d = stat_ctrl_q + STAT_W'(EX_VALID && ex_ctrl);
        stat_miss_d = stat_miss_q + STAT_W'(EX_MISPREDICT);
    end

    // State registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            // NOTE: the BTB is built from flops rather than RAM so reset can clear every valid bit and counter.
            for (int i = 0; i < ENTRIES; i++) entry_q[i] <= ENTRY_RST;
            stat_ctrl_q <= '0;
            stat_miss_q <= '0;
        end else begin
            entry_q     <= entry_d;
            stat_ctrl_q <= stat_ctrl_d;
            stat_miss_q <= stat_miss_d;
        end
    end

    assign STAT_CTRL = stat_ctrl_q;
    assign STAT_MISS = stat_miss_q;

endmodule

// File: tb/tb_otter_branch_predictor.sv
// Directed bench for otter_branch_predictor: default instance (64 entries,
// 2-bit counters, 32-bit stats) plus a small instance with 4-bit stats
// driven by the same inputs to observe statistic wrap.
module tb_otter_branch_predictor;

    logic        CLK, RESET, IF_VALID, EX_VALID, EX_IS_BRANCH, EX_IS_JUMP;
    logic        EX_TAKEN, EX_PRED_TAKEN, INVALIDATE;
    logic [31:0] IF_PC, EX_PC, EX_TARGET, EX_PRED_TARGET;
    logic        PRED_TAKEN, EX_MISPREDICT;
    logic [31:0] PRED_TARGET, EX_REDIRECT_PC, STAT_CTRL, STAT_MISS;
    logic        s_pred_taken, s_ex_mispredict;
    logic [31:0] s_pred_target, s_ex_redirect_pc;
    logic [3:0]  s_stat_ctrl, s_stat_miss;

    int checks = 0;
    int failures = 0;

    otter_branch_predictor dut (
        .CLK(CLK), .RESET(RESET), .IF_VALID(IF_VALID), .IF_PC(IF_PC),
        .PRED_TAKEN(PRED_TAKEN), .PRED_TARGET(PRED_TARGET),
        .EX_VALID(EX_VALID), .EX_PC(EX_PC), .EX_IS_BRANCH(EX_IS_BRANCH),
        .EX_IS_JUMP(EX_IS_JUMP), .EX_TAKEN(EX_TAKEN), .EX_TARGET(EX_TARGET),
        .EX_PRED_TAKEN(EX_PRED_TAKEN), .EX_PRED_TARGET(EX_PRED_TARGET),
        .INVALIDATE(INVALIDATE), .EX_MISPREDICT(EX_MISPREDICT),
        .EX_REDIRECT_PC(EX_REDIRECT_PC), .STAT_CTRL(STAT_CTRL), .STAT_MISS(STAT_MISS)
    );

    otter_branch_predictor #(.ENTRIES(4), .CNT_W(1), .STAT_W(4)) dut_small (
        .CLK(CLK), .RESET(RESET), .IF_VALID(IF_VALID), .IF_PC(IF_PC),
        .PRED_TAKEN(s_pred_taken), .PRED_TARGET(s_pred_target),
        .EX_VALID(EX_VALID), .EX_PC(EX_PC), .EX_IS_BRANCH(EX_IS_BRANCH),
        .EX_IS_JUMP(EX_IS_JUMP), .EX_TAKEN(EX_TAKEN), .EX_TARGET(EX_TARGET),
        .EX_PRED_TAKEN(EX_PRED_TAKEN), .EX_PRED_TARGET(EX_PRED_TARGET),
        .INVALIDATE(INVALIDATE), .EX_MISPREDICT(s_ex_mispredict),
        .EX_REDIRECT_PC(s_ex_redirect_pc), .STAT_CTRL(s_stat_ctrl), .STAT_MISS(s_stat_miss)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic ex_idle();
        EX_VALID = 0; EX_PC = 0; EX_IS_BRANCH = 0; EX_IS_JUMP = 0; EX_TAKEN = 0;
        EX_TARGET = 0; EX_PRED_TAKEN = 0; EX_PRED_TARGET = 0; INVALIDATE = 0;
    endtask

    task automatic ex_set(input logic [31:0] pc, input logic br, input logic jmp,
                          input logic tk, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptg);
        EX_VALID = 1; EX_PC = pc; EX_IS_BRANCH = br; EX_IS_JUMP = jmp; EX_TAKEN = tk;
        EX_TARGET = tgt; EX_PRED_TAKEN = ptk; EX_PRED_TARGET = ptg;
    endtask

    task automatic test_reset();
        IF_VALID = 1; IF_PC = 32'h100;
        #1;
        checks++; if (PRED_TAKEN !== 1'b0) begin failures++; $display("FAIL reset_pred_taken got=%0b exp=0", PRED_TAKEN); end
        checks++; if (PRED_TARGET !== 32'h104) begin failures++; $display("FAIL reset_pred_target got=%h exp=00000104", PRED_TARGET); end
        checks++; if (STAT_CTRL !== 32'd0) begin failures++; $display("FAIL reset_stat_ctrl got=%0d exp=0", STAT_CTRL); end
        checks++; if (STAT_MISS !== 32'd0) begin failures++; $display("FAIL reset_stat_miss got=%0d exp=0", STAT_MISS); end
        checks++; if (s_pred_taken !== 1'b0 || s_pred_target !== 32'h104) begin failures++; $display("FAIL reset_small_pred got=%0b/%h exp=0/00000104", s_pred_taken, s_pred_target); end
        checks++; if (s_ex_mispredict !== 1'b0 || s_ex_redirect_pc !== 32'h4) begin failures++; $display("FAIL reset_small_ex got=%0b/%h exp=0/00000004", s_ex_mispredict, s_ex_redirect_pc); end
    endtask

    task automatic test_train_taken();
        IF_PC = 32'h200;
        ex_set(32'h200, 1, 0, 1, 32'h180, 0, 32'h204);
        #1;
        checks++; if (PRED_TAKEN !== 1'b0) begin failures++; $display("FAIL same_cycle_pred got=%0b exp=0", PRED_TAKEN); end
        checks++; if (EX_MISPREDICT !== 1'b1) begin failures++; $display("FAIL first_taken_miss got=%0b exp=1", EX_MISPREDICT); end
        checks++; if (EX_REDIRECT_PC !== 32'h180) begin failures++; $display("FAIL first_taken_redirect got=%h exp=00000180", EX_REDIRECT_PC); end
        tick();                                   // allocate, cnt=2
        ex_idle(); #1;
        checks++; if (PRED_TAKEN !== 1'b1) begin failures++; $display("FAIL trained_pred_taken got=%0b exp=1", PRED_TAKEN); end
        checks++; if (PRED_TARGET !== 32'h180) begin failures++; $display("FAIL trained_pred_target got=%h exp=00000180", PRED_TARGET); end
        ex_set(32'h200, 1, 0, 1, 32'h180, 1, 32'h180);
        #1;
        checks++; if (EX_MISPREDICT !== 1'b0) begin failures++; $display("FAIL correct_pred_miss got=%0b exp=0", EX_MISPREDICT); end
        tick();                                   // cnt=3
        ex_idle(); #1;
        checks++; if (STAT_CTRL !== 32'd2 || STAT_MISS !== 32'd1) begin failures++; $display("FAIL stats_after_train got=%0d/%0d exp=2/1", STAT_CTRL, STAT_MISS); end
    endtask

    task automatic test_not_taken();
        IF_PC = 32'h200;
        ex_set(32'h200, 1, 0, 0, 32'h180, 1, 32'h180);
        #1;
        checks++; if (EX_MISPREDICT !== 1'b1) begin failures++; $display("FAIL nt_miss got=%0b exp=1", EX_MISPREDICT); end
        checks++; if (EX_REDIRECT_PC !== 32'h204) begin failures++; $display("FAIL nt_redirect got=%h exp=00000204", EX_REDIRECT_PC); end
        tick();                                   // cnt=2
        ex_idle(); #1;
        checks++; if (PRED_TAKEN !== 1'b1) begin failures++; $display("FAIL cnt2_pred got=%0b exp=1", PRED_TAKEN); end
        ex_set(32'h200, 1, 0, 0, 32'h180, 1, 32'h180);
        tick();                                   // cnt=1
        ex_idle(); #1;
        checks++; if (PRED_TAKEN !== 1'b0 || PRED_TARGET !== 32'h204) begin failures++; $display("FAIL cnt1_pred got=%0b/%h exp=0/00000204", PRED_TAKEN, PRED_TARGET); end
        ex_set(32'h200, 1, 0, 0, 32'h180, 0, 32'h204);
        #1;
        checks++; if (EX_MISPREDICT !== 1'b0) begin failures++; $display("FAIL nt_correct_miss got=%0b exp=0", EX_MISPREDICT); end
        tick();                                   // cnt=0
        tick();                                   // cnt stays 0
        ex_set(32'h200, 1, 0, 1, 32'h180, 0, 32'h204);
        #1;
        checks++; if (EX_MISPREDICT !== 1'b1 || EX_REDIRECT_PC !== 32'h180) begin failures++; $display("FAIL taken_after_sat got=%0b/%h exp=1/00000180", EX_MISPREDICT, EX_REDIRECT_PC); end
        tick();                                   // cnt=1
        ex_idle(); #1;
        checks++; if (PRED_TAKEN !== 1'b0) begin failures++; $display("FAIL floor_clamp_pred got=%0b exp=0", PRED_TAKEN); end
        ex_set(32'h200, 1, 0, 1, 32'h180, 0, 32'h204);
        tick();                                   // cnt=2
        ex_idle(); #1;
        checks++; if (PRED_TAKEN !== 1'b1 || PRED_TARGET !== 32'h180) begin failures++; $display("FAIL retrained_pred got=%0b/%h exp=1/00000180", PRED_TAKEN, PRED_TARGET); end
        checks++; if (STAT_CTRL !== 32'd8 || STAT_MISS !== 32'd5) begin failures++; $display("FAIL stats_after_nt got=%0d/%0d exp=8/5", STAT_CTRL, STAT_MISS); end
    endtask

    task automatic test_alias_kill();
        IF_PC = 32'h300;
        ex_set(32'h300, 0, 0, 0, 32'h0, 1, 32'h380);
        #1;
        checks++; if (PRED_TAKEN !== 1'b0 || PRED_TARGET !== 32'h304) begin failures++; $display("FAIL alias_no_hit got=%0b/%h exp=0/00000304", PRED_TAKEN, PRED_TARGET); end
        checks++; if (EX_MISPREDICT !== 1'b1 || EX_REDIRECT_PC !== 32'h304) begin failures++; $display("FAIL alias_ex got=%0b/%h exp=1/00000304", EX_MISPREDICT, EX_REDIRECT_PC); end
        tick();
        ex_idle(); IF_PC = 32'h200; #1;
        checks++; if (PRED_TAKEN !== 1'b1) begin failures++; $display("FAIL other_tag_kept got=%0b exp=1", PRED_TAKEN); end
        ex_set(32'h200, 0, 0, 0, 32'h0, 0, 32'h204);
        #1;
        checks++; if (EX_MISPREDICT !== 1'b0) begin failures++; $display("FAIL nonctrl_nopred_miss got=%0b exp=0", EX_MISPREDICT); end
        ex_set(32'h200, 0, 0, 0, 32'h0, 1, 32'h180);
        #1;
        checks++; if (EX_MISPREDICT !== 1'b1 || EX_REDIRECT_PC !== 32'h204) begin failures++; $display("FAIL kill_ex got=%0b/%h exp=1/00000204", EX_MISPREDICT, EX_REDIRECT_PC); end
        tick();
        ex_idle(); #1;
        checks++; if (PRED_TAKEN !== 1'b0 || PRED_TARGET !== 32'h204) begin failures++; $display("FAIL killed_pred got=%0b/%h exp=0/00000204", PRED_TAKEN, PRED_TARGET); end
        checks++; if (STAT_CTRL !== 32'd8 || STAT_MISS !== 32'd7) begin failures++; $display("FAIL stats_after_alias got=%0d/%0d exp=8/7", STAT_CTRL, STAT_MISS); end
    endtask

    task automatic test_jump_invalidate();
        IF_PC = 32'h40;
        ex_set(32'h40, 0, 1, 1, 32'h800, 0, 32'h44);
        #1;
        checks++; if (EX_MISPREDICT !== 1'b1 || EX_REDIRECT_PC !== 32'h800) begin failures++; $display("FAIL jalr_first got=%0b/%h exp=1/00000800", EX_MISPREDICT, EX_REDIRECT_PC); end
        tick();
        ex_idle(); #1;
        checks++; if (PRED_TAKEN !== 1'b1 || PRED_TARGET !== 32'h800) begin failures++; $display("FAIL jalr_pred1 got=%0b/%h exp=1/00000800", PRED_TAKEN, PRED_TARGET); end
        ex_set(32'h40, 0, 1, 1, 32'h900, 1, 32'h800);
        #1;
        checks++; if (EX_MISPREDICT !== 1'b1 || EX_REDIRECT_PC !== 32'h900) begin failures++; $display("FAIL jalr_target_miss got=%0b/%h exp=1/00000900", EX_MISPREDICT, EX_REDIRECT_PC); end
        tick();
        ex_idle(); #1;
        checks++; if (PRED_TAKEN !== 1'b1 || PRED_TARGET !== 32'h900) begin failures++; $display("FAIL jalr_pred2 got=%0b/%h exp=1/00000900", PRED_TAKEN, PRED_TARGET); end
        ex_set(32'h500, 1, 0, 1, 32'h600, 0, 32'h504);
        INVALIDATE = 1;
        tick();
        ex_idle(); #1;
        checks++; if (PRED_TAKEN !== 1'b0 || PRED_TARGET !== 32'h44) begin failures++; $display("FAIL inval_jalr got=%0b/%h exp=0/00000044", PRED_TAKEN, PRED_TARGET); end
        IF_PC = 32'h500; #1;
        checks++; if (PRED_TAKEN !== 1'b0 || PRED_TARGET !== 32'h504) begin failures++; $display("FAIL inval_wins_train got=%0b/%h exp=0/00000504", PRED_TAKEN, PRED_TARGET); end
        checks++; if (STAT_CTRL !== 32'd11 || STAT_MISS !== 32'd10) begin failures++; $display("FAIL stats_after_jump got=%0d/%0d exp=11/10", STAT_CTRL, STAT_MISS); end
    endtask

    task automatic test_reset_mid();
        IF_PC = 32'h40;
        ex_set(32'h40, 0, 1, 1, 32'h800, 0, 32'h44);
        tick();
        checks++; if (PRED_TAKEN !== 1'b1) begin failures++; $display("FAIL pre_reset_pred got=%0b exp=1", PRED_TAKEN); end
        RESET = 1;
        #1;
        checks++; if (STAT_CTRL !== 32'd0 || STAT_MISS !== 32'd0) begin failures++; $display("FAIL async_reset_stats got=%0d/%0d exp=0/0", STAT_CTRL, STAT_MISS); end
        checks++; if (PRED_TAKEN !== 1'b0 || PRED_TARGET !== 32'h44) begin failures++; $display("FAIL async_reset_pred got=%0b/%h exp=0/00000044", PRED_TAKEN, PRED_TARGET); end
        checks++; if (EX_MISPREDICT !== 1'b1 || EX_REDIRECT_PC !== 32'h800) begin failures++; $display("FAIL reset_ex_comb got=%0b/%h exp=1/00000800", EX_MISPREDICT, EX_REDIRECT_PC); end
        tick();                                   // edge under reset must not train
        ex_idle();
        RESET = 0;
        tick();
        checks++; if (PRED_TAKEN !== 1'b0 || STAT_CTRL !== 32'd0) begin failures++; $display("FAIL post_reset got=%0b/%0d exp=0/0", PRED_TAKEN, STAT_CTRL); end
    endtask

    task automatic test_stat_wrap();
        for (int i = 0; i < 17; i++) begin
            ex_set(32'h1000, 1, 0, 0, 32'h0, 0, 32'h1004);
            tick();
        end
        ex_idle(); IF_PC = 32'h1000; #1;
        checks++; if (STAT_CTRL !== 32'd17) begin failures++; $display("FAIL stat_ctrl_17 got=%0d exp=17", STAT_CTRL); end
        checks++; if (s_stat_ctrl !== 4'd1) begin failures++; $display("FAIL stat_wrap_4bit got=%0d exp=1", s_stat_ctrl); end
        checks++; if (STAT_MISS !== 32'd0 || s_stat_miss !== 4'd0) begin failures++; $display("FAIL stat_miss_zero got=%0d/%0d exp=0/0", STAT_MISS, s_stat_miss); end
        checks++; if (s_pred_taken !== 1'b0 || s_pred_target !== 32'h1004) begin failures++; $display("FAIL small_no_alloc got=%0b/%h exp=0/00001004", s_pred_taken, s_pred_target); end
    endtask

    initial begin
        RESET = 1; IF_VALID = 0; IF_PC = 0;
        ex_idle();
        repeat (2) @(posedge CLK);
        #1 RESET = 0;
        test_reset();
        test_train_taken();
        test_not_taken();
        test_alias_kill();
        test_jump_invalidate();
        test_reset_mid();
        test_stat_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
